// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and saturation limits for the fixed-point ALU
package alu_pkg;

    localparam int DEF_INT_W  = 6;
    localparam int DEF_FRAC_W = 10;

    localparam int OP_ADD     = 0;
    localparam int OP_SUB     = 1;
    localparam int OP_MUL     = 2;
    localparam int OP_MAC     = 3;
    localparam int OP_CLZ     = 4;
    localparam int OP_LFSR    = 5;
    localparam int OP_ACC_CLR = 6;
    localparam int OP_ACC_RD  = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Largest positive value of a w-bit two's complement word
    function automatic logic signed [63:0] sat_hi(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative value of a w-bit two's complement word
    function automatic logic signed [63:0] sat_lo(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/alu_fx_rne_sat.sv
// rtl/alu_fx_rne_sat.sv - round-to-nearest-even and saturate a wide product back to DATA_W
module alu_fx_rne_sat
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 10
) (
    input  logic signed [2*DATA_W:0] prod,
    output logic        [DATA_W-1:0] res
);

    localparam int WW = 2 * DATA_W + 1;
    // One spare bit above the kept field so the rounding increment cannot wrap
    localparam int KW = WW - FRAC_W + 1;
    localparam logic signed [KW-1:0] HI   = KW'(sat_hi(DATA_W));
    localparam logic signed [KW-1:0] LO   = KW'(sat_lo(DATA_W));
    localparam logic [FRAC_W-1:0]    HALF = FRAC_W'(1) << (FRAC_W - 1);

    logic signed [KW-1:0]     kept;
    logic signed [KW-1:0]     rounded;
    logic        [FRAC_W-1:0] dropped;
    logic                     round_up;

    // Drop the fractional LSBs with ties going to the even neighbour, then clamp
    always_comb begin
        kept     = KW'(prod >>> FRAC_W);
        dropped  = prod[FRAC_W-1:0];
        round_up = (dropped > HALF) || ((dropped == HALF) && kept[0]);
        rounded  = kept + {{(KW-1){1'b0}}, round_up};
        if (rounded > HI) begin
            res = HI[DATA_W-1:0];
        end else if (rounded < LO) begin
            res = LO[DATA_W-1:0];
        end else begin
            res = rounded[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/alu_seq_fx.sv
// rtl/alu_seq_fx.sv - handshaked fixed-point ALU with MAC accumulator and iterative LFSR
module alu_seq_fx
    import alu_pkg::*;
#(
    parameter int                 INT_W     = DEF_INT_W,
    parameter int                 FRAC_W    = DEF_FRAC_W,
    parameter int                 DATA_W    = INT_W + FRAC_W,
    parameter int                 INST_W    = 4,
    parameter int                 STEP_W    = 8,
    parameter logic [DATA_W-1:0]  LFSR_TAPS = 16'hB400
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic        [INST_W-1:0] i_inst,
    input  logic signed [DATA_W-1:0] i_data_a,
    input  logic signed [DATA_W-1:0] i_data_b,
    output logic                     o_busy,
    output logic                     o_valid,
    output logic        [DATA_W-1:0] o_data,
    output logic                     o_err
);

    localparam int                WW     = 2 * DATA_W + 1;
    localparam logic [DATA_W-1:0] SAT_HI = DATA_W'(sat_hi(DATA_W));
    localparam logic [DATA_W-1:0] SAT_LO = DATA_W'(sat_lo(DATA_W));

    state_t              state;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   lfsr_q;
    logic [STEP_W-1:0]   cnt;

    logic signed [DATA_W:0] add_w;
    logic signed [DATA_W:0] sub_w;
    logic [DATA_W-1:0]      add_res;
    logic [DATA_W-1:0]      sub_res;
    logic signed [WW-1:0]   a_ext;
    logic signed [WW-1:0]   b_ext;
    logic signed [WW-1:0]   acc_ext;
    logic signed [WW-1:0]   prod_w;
    logic signed [WW-1:0]   mac_w;
    logic [DATA_W-1:0]      mul_res;
    logic [DATA_W-1:0]      mac_res;
    logic [DATA_W-1:0]      clz_res;
    logic [DATA_W-1:0]      lfsr_next;
    logic [STEP_W-1:0]      step_n;

    // Wide add/sub with overflow clamp, and the widened product/MAC operands
    always_comb begin
        add_w   = {i_data_a[DATA_W-1], i_data_a} + {i_data_b[DATA_W-1], i_data_b};
        sub_w   = {i_data_a[DATA_W-1], i_data_a} - {i_data_b[DATA_W-1], i_data_b};
        add_res = (add_w[DATA_W] != add_w[DATA_W-1]) ? (add_w[DATA_W] ? SAT_LO : SAT_HI)
                                                     : add_w[DATA_W-1:0];
        sub_res = (sub_w[DATA_W] != sub_w[DATA_W-1]) ? (sub_w[DATA_W] ? SAT_LO : SAT_HI)
                                                     : sub_w[DATA_W-1:0];
        a_ext   = {{(WW-DATA_W){i_data_a[DATA_W-1]}}, i_data_a};
        b_ext   = {{(WW-DATA_W){i_data_b[DATA_W-1]}}, i_data_b};
        acc_ext = {{(WW-DATA_W){acc[DATA_W-1]}}, acc};
        prod_w  = a_ext * b_ext;
        mac_w   = prod_w + (acc_ext <<< FRAC_W);
    end

    // Leading-zero count: the highest set bit wins because it is visited last
    always_comb begin
        clz_res = DATA_W'(DATA_W);
        for (int i = 0; i < DATA_W; i++) begin
            if (i_data_a[i]) begin
                clz_res = DATA_W'(DATA_W - 1 - i);
            end
        end
    end

    // One Fibonacci LFSR step and the requested step count
    always_comb begin
        lfsr_next = {lfsr_q[DATA_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        step_n    = i_data_b[STEP_W-1:0];
    end

    alu_fx_rne_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mul_rne (
        .prod (prod_w),
        .res  (mul_res)
    );

    alu_fx_rne_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mac_rne (
        .prod (mac_w),
        .res  (mac_res)
    );

    // Control FSM: single-cycle ops issue from IDLE, LFSR iterates in RUN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            acc     <= '0;
            lfsr_q  <= '0;
            cnt     <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_err   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_valid && !o_busy) begin
                        o_valid <= 1'b1;
                        o_err   <= 1'b0;
                        case (i_inst)
                            INST_W'(OP_ADD):     o_data <= add_res;
                            INST_W'(OP_SUB):     o_data <= sub_res;
                            INST_W'(OP_MUL):     o_data <= mul_res;
                            INST_W'(OP_MAC): begin
                                o_data <= mac_res;
                                acc    <= mac_res;
                            end
                            INST_W'(OP_CLZ):     o_data <= clz_res;
                            INST_W'(OP_LFSR): begin
                                if (step_n == '0) begin
                                    o_data <= i_data_a;
                                end else begin
                                    o_valid <= 1'b0;
                                    lfsr_q  <= i_data_a;
                                    cnt     <= step_n;
                                    o_busy  <= 1'b1;
                                    state   <= ST_RUN;
                                end
                            end
                            INST_W'(OP_ACC_CLR): begin
                                o_data <= '0;
                                acc    <= '0;
                            end
                            INST_W'(OP_ACC_RD):  o_data <= acc;
                            default: begin
                                o_data <= '0;
                                o_err  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    lfsr_q <= lfsr_next;
                    cnt    <= cnt - STEP_W'(1);
                    if (cnt == STEP_W'(1)) begin
                        o_data  <= lfsr_next;
                        o_valid <= 1'b1;
                        o_err   <= 1'b0;
                        o_busy  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_fx.sv
// tb/tb_alu_seq_fx.sv - directed self-checking bench for alu_seq_fx
module tb_alu_seq_fx;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        vld  = 1'b0;
    logic [3:0]  inst = '0;
    logic [15:0] da   = '0;
    logic [15:0] db   = '0;
    logic        busy;
    logic        ovld;
    logic        err;
    logic [15:0] dout;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq_fx dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (vld),
        .i_inst   (inst),
        .i_data_a (da),
        .i_data_b (db),
        .o_busy   (busy),
        .o_valid  (ovld),
        .o_data   (dout),
        .o_err    (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        vld  = 1'b1;
        inst = op;
        da   = a;
        db   = b;
    endtask

    task automatic op_chk(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp, input logic exp_err);
        drive(op, a, b);
        @(posedge clk);
        #1;
        check({tag, ".valid"}, ovld, 1);
        check({tag, ".data"}, dout, exp);
        check({tag, ".err"}, err, exp_err);
        check({tag, ".busy"}, busy, 0);
    endtask

    task automatic edge_chk(input string tag, input logic exp_busy, input logic exp_valid);
        @(posedge clk);
        #1;
        check({tag, ".busy"}, busy, exp_busy);
        check({tag, ".valid"}, ovld, exp_valid);
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        vld = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".valid"}, ovld, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.valid", ovld, 0);
        check("rst.data", dout, 0);
        check("rst.err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        op_chk("add_sat", 4'd0, 16'h7C00, 16'h0800, 16'h7FFF, 1'b0);
        idle_chk("add_one_strobe");
        op_chk("sub_sat", 4'd1, 16'h8400, 16'h0800, 16'h8000, 1'b0);
        op_chk("add_plain", 4'd0, 16'h0400, 16'h0C00, 16'h1000, 1'b0);

        op_chk("mul_tie_up", 4'd2, 16'h0600, 16'h0001, 16'h0002, 1'b0);
        op_chk("mul_tie_dn", 4'd2, 16'h0200, 16'h0001, 16'h0000, 1'b0);
        op_chk("mul_neg", 4'd2, 16'hFC00, 16'h0C00, 16'hF400, 1'b0);

        op_chk("acc_clr", 4'd6, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        op_chk("mac1", 4'd3, 16'h0800, 16'h0C00, 16'h1800, 1'b0);
        op_chk("mac2", 4'd3, 16'h0800, 16'h0C00, 16'h3000, 1'b0);
        op_chk("mac3", 4'd3, 16'h1000, 16'h1000, 16'h7000, 1'b0);
        op_chk("mac4", 4'd3, 16'h1000, 16'h1000, 16'h7FFF, 1'b0);
        op_chk("acc_rd", 4'd7, 16'h0000, 16'h0000, 16'h7FFF, 1'b0);

        op_chk("clz_zero", 4'd4, 16'h0000, 16'h0000, 16'h0010, 1'b0);
        op_chk("clz_0100", 4'd4, 16'h0100, 16'h0000, 16'h0007, 1'b0);
        op_chk("clz_8000", 4'd4, 16'h8000, 16'h0000, 16'h0000, 1'b0);
        op_chk("illegal", 4'hF, 16'h1234, 16'h5678, 16'h0000, 1'b1);
        op_chk("acc_kept", 4'd7, 16'h0000, 16'h0000, 16'h7FFF, 1'b0);
        idle_chk("post_illegal");

        // LFSR runs with i_valid held high throughout; busy-time offers must be dropped
        drive(4'd5, 16'h0001, 16'd3);
        edge_chk("lfsr3.e0", 1'b1, 1'b0);
        @(negedge clk);
        inst = 4'd0;
        da   = 16'h0001;
        db   = 16'h0001;
        edge_chk("lfsr3.e1", 1'b1, 1'b0);
        edge_chk("lfsr3.e2", 1'b1, 1'b0);
        edge_chk("lfsr3.e3", 1'b0, 1'b1);
        check("lfsr3.data", dout, 16'h0008);
        check("lfsr3.err", err, 0);
        @(negedge clk);
        inst = 4'd5;
        da   = 16'h8000;
        db   = 16'd1;
        edge_chk("lfsr1.e0", 1'b1, 1'b0);
        @(negedge clk);
        da   = 16'h1234;
        db   = 16'd0;
        edge_chk("lfsr1.e1", 1'b0, 1'b1);
        check("lfsr1.data", dout, 16'h0001);
        edge_chk("lfsr0", 1'b0, 1'b1);
        check("lfsr0.data", dout, 16'h1234);
        idle_chk("post_lfsr");

        // Asynchronous reset in the middle of a long LFSR run
        drive(4'd5, 16'h0001, 16'd200);
        repeat (5) @(posedge clk);
        #3;
        check("pre_rst.busy", busy, 1);
        rst = 1'b1;
        vld = 1'b0;
        #1;
        check("async_rst.busy", busy, 0);
        check("async_rst.valid", ovld, 0);
        check("async_rst.data", dout, 0);
        @(negedge clk);
        rst = 1'b0;
        op_chk("mac_after_rst", 4'd3, 16'h0400, 16'h0400, 16'h0400, 1'b0);
        idle_chk("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
